inst_seq_ctrl: RTL and testbench
================================

INST_SEQ_CTRL -- requirements
Module: inst_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, instruction memory address width (16 words).
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter HALT_OP, default 5'b11111, opcode value in ir[31:27] that halts sequencing.
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 SHALL have port start  input  1  begin sequencing from IDLE.
REQ-007 SHALL have port stall  input  1  hold in EXECUTE while high.
REQ-008 SHALL have port jump_en  input  1  take branch; sampled in EXECUTE.
REQ-009 SHALL have port jump_addr  input  ADDR_W  branch target; sampled with jump_en.
REQ-010 SHALL have port mem_rdata  input  DATA_W  instruction memory read data, combinational from mem_addr.
REQ-011 SHALL have port mem_addr  output  ADDR_W  instruction memory address, always equal to pc.
REQ-012 SHALL have port ir  output  DATA_W  instruction register.
REQ-013 SHALL have port pc  output  ADDR_W  program counter.
REQ-014 SHALL have port state  output  3  FSM encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6.
REQ-015 SHALL have port ir_valid  output  1  high in DECODE through WRITEBACK.
REQ-016 SHALL have port halted  output  1  high while in HALT.
REQ-017 SHALL have port instr_cnt  output  16  retired-instruction count.

Function
REQ-018 IDLE SHALL move to FETCH on the first cycle start=1; otherwise it SHALL remain in IDLE.
REQ-019 FETCH SHALL last one cycle, load ir <= mem_rdata (addressed by pc), and move to DECODE.
REQ-020 DECODE SHALL move to HALT if ir[31:27]==HALT_OP; otherwise it SHALL move to EXECUTE.
REQ-021 EXECUTE SHALL remain in EXECUTE while stall=1.
REQ-022 On stall=0, EXECUTE SHALL move to MEMORY and latch jump_en/jump_addr into a pending-branch register.
REQ-023 MEMORY and WRITEBACK SHALL each last exactly one cycle.
REQ-024 On WRITEBACK exit, pc SHALL load the pending target if a branch is pending, else pc+1.
REQ-025 On WRITEBACK exit, the pending branch SHALL clear, instr_cnt SHALL increment, and the FSM SHALL move to FETCH.
REQ-026 Unstalled, an instruction SHALL take exactly 5 cycles from FETCH entry to the next FETCH entry.
REQ-027 pc+1 SHALL wrap modulo 2^ADDR_W (15 -> 0 for ADDR_W=4) with no flag.
REQ-028 instr_cnt SHALL saturate at 16'hFFFF.
REQ-029 HALT SHALL be terminal until reset; start, stall and jump_en SHALL be ignored in HALT.
REQ-030 A halting instruction SHALL not increment instr_cnt, and pc SHALL hold the halting instruction's address.
REQ-031 jump_en, jump_addr and stall SHALL be ignored in every state other than EXECUTE.
REQ-032 start SHALL be ignored outside IDLE.
REQ-033 ir SHALL change only in FETCH.
REQ-034 Illegal state encodings (7) SHALL return to IDLE on the next clock.

Reset
REQ-035 When rst_n=0 at a rising clk, in any state including mid-instruction or HALT, the block SHALL set state=IDLE, pc=0, ir=0, instr_cnt=0, ir_valid=0, halted=0, and clear the pending branch.
REQ-036 mem_addr SHALL read 0 after reset.
REQ-037 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-038 Scenario: memory words 0..3 nonzero, non-halt; start pulse -> ir=mem[0], then FETCH every 5 cycles, pc 0,1,2,3; instr_cnt=3 at the 4th FETCH.
REQ-039 Scenario: stall=1 for 3 cycles in EXECUTE of instruction at pc=2 -> 8-cycle instruction, pc=3 afterward.
REQ-040 Scenario: jump_en=1, jump_addr=9 in EXECUTE at pc=1 -> next FETCH with pc=9.
REQ-041 Scenario: jump_en pulsed in MEMORY -> ignored, pc=pc+1.
REQ-042 Scenario: mem[4]={5'b11111,27'h0} -> HALT after DECODE, halted=1, pc=4, instr_cnt=4; later start=1 -> no change.
REQ-043 Scenario: pc=15 without jump -> next pc=0.
REQ-044 Scenario: rst_n=0 asserted in EXECUTE -> next cycle state=0, pc=0, ir=0, instr_cnt=0.

Source files
------------

// File: rtl/inst_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// walk over an external instruction memory, with stall, branch and halt handling.
module inst_seq_ctrl #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter logic [4:0]  HALT_OP = 5'b11111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              ir_valid,
    output logic              halted,
    output logic [15:0]       instr_cnt
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned OP_LSB = DATA_W - OP_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_pend_q, br_pend_d;
    logic [ADDR_W-1:0]  br_addr_q, br_addr_d;
    logic               ir_valid_q, ir_valid_d;
    logic               halted_q, halted_d;

    // Next-state and datapath updates; branch request is captured when EXECUTE retires.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        br_pend_d = br_pend_q;
        br_addr_d = br_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = mem_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (ir_q[OP_LSB +: OP_W] == HALT_OP) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (!stall) begin
                    br_pend_d = jump_en;
                    br_addr_d = jump_addr;
                    state_d   = S_MEMORY;
                end
            end
            S_MEMORY: begin
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_d      = br_pend_q ? br_addr_q : pc_q + ADDR_W'(1);
                br_pend_d = 1'b0;
                cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ir_valid_d = (state_d == S_DECODE) || (state_d == S_EXECUTE) ||
                     (state_d == S_MEMORY) || (state_d == S_WRITEBACK);
        halted_d   = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            cnt_q      <= '0;
            br_pend_q  <= 1'b0;
            br_addr_q  <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            br_pend_q  <= br_pend_d;
            br_addr_q  <= br_addr_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign state     = state_q;
    assign pc        = pc_q;
    assign mem_addr  = pc_q;
    assign ir        = ir_q;
    assign instr_cnt = cnt_q;
    assign ir_valid  = ir_valid_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// Bench for inst_seq_ctrl: directed scenarios plus randomized instructions,
// checked against an instruction-level model of pc, count and phase sequence.
module tb_inst_seq_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              stall;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        state;
    logic              ir_valid;
    logic              halted;
    logic [15:0]       instr_cnt;

    logic [DATA_W-1:0] mem [16];

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] mpc;
    logic [15:0]       mcnt;
    bit                hit;

    inst_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALT_OP(5'b11111)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .jump_en(jump_en), .jump_addr(jump_addr), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .ir(ir), .pc(pc), .state(state),
        .ir_valid(ir_valid), .halted(halted), .instr_cnt(instr_cnt)
    );

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random values on inputs that the current phase must ignore.
    task automatic noise();
        stall     = 1'($urandom);
        jump_en   = 1'($urandom);
        jump_addr = ADDR_W'($urandom);
        start     = 1'($urandom);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_ir"}, ir, 32'd0);
        chk({tag, "_cnt"}, 32'(instr_cnt), 32'd0);
        chk({tag, "_irv"}, 32'(ir_valid), 32'd0);
        chk({tag, "_halt"}, 32'(halted), 32'd0);
    endtask

    task automatic chk_fetch();
        chk("fetch_state", 32'(state), 32'd1);
        chk("fetch_pc", 32'(pc), 32'(mpc));
        chk("fetch_addr", 32'(mem_addr), 32'(mpc));
        chk("fetch_cnt", 32'(instr_cnt), 32'(mcnt));
        chk("fetch_irv", 32'(ir_valid), 32'd0);
    endtask

    // One instruction starting with the DUT observed in FETCH; the model
    // expects 5 + stalls cycles and the pc/count effects at the end.
    task automatic run_instr(input int stalls, input bit jmp, input logic [ADDR_W-1:0] ja,
                             output bit halt_seen);
        logic [DATA_W-1:0] word;
        halt_seen = 1'b0;
        word = mem[mpc];
        chk_fetch();
        noise(); step();
        chk("dec_state", 32'(state), 32'd2);
        chk("dec_ir", ir, word);
        chk("dec_irv", 32'(ir_valid), 32'd1);
        if (word[31:27] == 5'b11111) begin
            noise(); step();
            chk("halt_state", 32'(state), 32'd6);
            chk("halt_flag", 32'(halted), 32'd1);
            chk("halt_irv", 32'(ir_valid), 32'd0);
            chk("halt_pc", 32'(pc), 32'(mpc));
            chk("halt_cnt", 32'(instr_cnt), 32'(mcnt));
            halt_seen = 1'b1;
            return;
        end
        noise(); step();
        chk("exe_state", 32'(state), 32'd3);
        for (int k = 0; k < stalls; k++) begin
            stall = 1'b1; jump_en = 1'($urandom); jump_addr = ADDR_W'($urandom);
            step();
            chk("stall_state", 32'(state), 32'd3);
        end
        stall = 1'b0; jump_en = jmp; jump_addr = ja;
        step();
        chk("mem_state", 32'(state), 32'd4);
        noise(); jump_en = 1'b1; jump_addr = ~ja;
        step();
        chk("wb_state", 32'(state), 32'd5);
        chk("wb_pc", 32'(pc), 32'(mpc));
        chk("wb_ir", ir, word);
        noise(); step();
        mpc  = jmp ? ja : ADDR_W'(mpc + 1);
        mcnt = (mcnt == 16'hFFFF) ? mcnt : mcnt + 16'd1;
    endtask

    task automatic fill_mem();
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            w[31] = 1'b0;
            w[0]  = 1'b1;
            mem[i] = w;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_addr = '0;
        fill_mem();
        mpc = '0; mcnt = '0;
        step(); step();
        chk_reset_state("rst");
        rst_n = 1'b1;

        // IDLE ignores stall/jump while start is low.
        for (int i = 0; i < 3; i++) begin
            stall = 1'($urandom); jump_en = 1'b1; jump_addr = ADDR_W'($urandom); start = 1'b0;
            step();
            chk("idle_hold", 32'(state), 32'd0);
        end
        start = 1'b1; step(); start = 1'b0;

        run_instr(0, 1'b0, '0, hit);
        run_instr(0, 1'b0, '0, hit);
        run_instr(3, 1'b0, '0, hit);
        chk_fetch();
        chk("cnt_at_4th", 32'(instr_cnt), 32'd3);
        run_instr(0, 1'b0, '0, hit);
        run_instr(1, 1'b1, 4'd9, hit);
        chk_fetch();
        run_instr(0, 1'b1, 4'd15, hit);
        run_instr(2, 1'b0, '0, hit);
        chk("wrap_pc", 32'(pc), 32'd0);

        for (int n = 0; n < 24; n++) begin
            run_instr(int'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3),
                      ADDR_W'($urandom), hit);
        end
        chk_fetch();

        // Reset while in EXECUTE, with every other input active.
        noise(); step(); noise(); step();
        chk("pre_rst_exe", 32'(state), 32'd3);
        rst_n = 1'b0; start = 1'b1; stall = 1'b0; jump_en = 1'b1; jump_addr = 4'd7;
        step();
        chk_reset_state("rst_exe");
        rst_n = 1'b1; start = 1'b0;
        step();
        chk("idle_after_rst", 32'(state), 32'd0);
        mpc = '0; mcnt = '0;

        // Halting program: four ordinary instructions then a halt word at 4.
        mem[4] = {5'b11111, 27'h0};
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) run_instr(int'($urandom_range(0, 2)), 1'b0, '0, hit);
        run_instr(0, 1'b0, '0, hit);
        chk("halt_seen", 32'(hit), 32'd1);
        chk("halt_pc4", 32'(pc), 32'd4);
        chk("halt_cnt4", 32'(instr_cnt), 32'd4);
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; stall = 1'($urandom); jump_en = 1'b1; jump_addr = ADDR_W'($urandom);
            step();
            chk("halt_stay", 32'(state), 32'd6);
            chk("halt_stay_pc", 32'(pc), 32'd4);
            chk("halt_stay_cnt", 32'(instr_cnt), 32'd4);
            chk("halt_stay_ir", ir, {5'b11111, 27'h0});
        end
        rst_n = 1'b0; step();
        chk_reset_state("rst_halt");
        rst_n = 1'b1; start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
